// File: rtl/float_class_pkg.sv
// Shared constants and helpers for the float classifying FIFO.
// Entry layout (MSB..LSB): {sign, exponent, significand, flags[3:0]}.
package float_class_pkg;

  // Number of classification flags carried with each entry.
  localparam int FLAG_W = 4;

  // Bit positions of the classification flags within the flag field.
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_SUB  = 1;
  localparam int FLAG_INF  = 2;
  localparam int FLAG_NAN  = 3;

  // Widest exponent field the all-ones helper can inspect.
  localparam int MAX_EXP_W = 64;

  // Packed float word width: sign + exponent + significand.
  function automatic int word_width(input int exp_w, input int sig_w);
    return 1 + exp_w + sig_w;
  endfunction

  // Stored entry width: packed word plus the classification flags.
  function automatic int entry_width(input int exp_w, input int sig_w);
    return word_width(exp_w, sig_w) + FLAG_W;
  endfunction

  // True when the low exp_w bits of exp_val are all ones.
  function automatic logic exp_all_ones(input logic [MAX_EXP_W-1:0] exp_val,
                                        input int exp_w);
    logic ones;
    ones = 1'b1;
    for (int i = 0; i < MAX_EXP_W; i++) begin
      if (i < exp_w && !exp_val[i]) ones = 1'b0;
    end
    return ones;
  endfunction

endpackage

// File: rtl/float_classify.sv
// Purely combinational field splitter and classifier for one packed float.
// Flags are mutually exclusive; all zero means a normal number.
module float_classify
  import float_class_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int SIG_W = 23
) (
  input  logic [EXP_W+SIG_W:0] word,
  output logic                 sign,
  output logic [EXP_W-1:0]     exponent,
  output logic [SIG_W-1:0]     significand,
  output logic [FLAG_W-1:0]    flags
);

  logic exp_ones;
  logic exp_zero;
  logic sig_zero;

  assign sign        = word[EXP_W+SIG_W];
  assign exponent    = word[SIG_W +: EXP_W];
  assign significand = word[SIG_W-1:0];

  // Derive the class flags from the exponent/significand extremes.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    flags    = '0;
    exp_ones = exp_all_ones(MAX_EXP_W'(exponent), EXP_W);
    exp_zero = (exponent == '0);
    sig_zero = (significand == '0);
    flags[FLAG_ZERO] = exp_zero &  sig_zero;
    flags[FLAG_SUB]  = exp_zero & !sig_zero;
    flags[FLAG_INF]  = exp_ones &  sig_zero;
    flags[FLAG_NAN]  = exp_ones & !sig_zero;
  end

endmodule

// File: rtl/float_class_fifo.sv
// Float classifying FIFO: splits and classifies incoming float words and
// buffers {sign, exponent, significand, flags} in a DEPTH-entry FIFO.
// Optional macro FLOAT_CLASS_FIFO_DONTCARE_ZERO_EN forces the head fields
// and flags to zero while the FIFO is empty.
module float_class_fifo
  import float_class_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int SIG_W = 23,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       io_flush,
  input  logic                       io_in_valid,
  output logic                       io_in_ready,
  input  logic [EXP_W+SIG_W:0]       io_in_bits,
  output logic                       io_out_valid,
  input  logic                       io_out_ready,
  output logic                       io_out_sign,
  output logic [EXP_W-1:0]           io_out_exponent,
  output logic [SIG_W-1:0]           io_out_significand,
  output logic                       io_out_is_zero,
  output logic                       io_out_is_subnormal,
  output logic                       io_out_is_inf,
  output logic                       io_out_is_nan,
  output logic [$clog2(DEPTH+1)-1:0] io_count
);

  localparam int ENTRY_W = entry_width(EXP_W, SIG_W);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH+1);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic               in_sign;
  logic [EXP_W-1:0]   in_exponent;
  logic [SIG_W-1:0]   in_significand;
  logic [FLAG_W-1:0]  in_flags;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;
  logic [ENTRY_W-1:0] head_vis;

  float_classify #(
    .EXP_W(EXP_W),
    .SIG_W(SIG_W)
  ) u_classify (
    .word       (io_in_bits),
    .sign       (in_sign),
    .exponent   (in_exponent),
    .significand(in_significand),
    .flags      (in_flags)
  );

  assign io_in_ready  = (count != CNT_W'(DEPTH));
  assign io_out_valid = (count != '0);
  assign push         = io_in_valid & io_in_ready & ~io_flush;
  assign pop          = io_out_valid & io_out_ready & ~io_flush;
  assign io_count     = count;

  // Pointer and occupancy bookkeeping; flush wins over any push or pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (io_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage write port.
  // NOTE: the storage array has no reset; validity is tracked by count alone.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {in_sign, in_exponent, in_significand, in_flags};
  end

  assign head = mem[rd_ptr];

`ifdef FLOAT_CLASS_FIFO_DONTCARE_ZERO_EN
  assign head_vis = io_out_valid ? head : '0;
`else
  assign head_vis = head;
`endif

  assign io_out_sign         = head_vis[ENTRY_W-1];
  assign io_out_exponent     = head_vis[FLAG_W+SIG_W +: EXP_W];
  assign io_out_significand  = head_vis[FLAG_W +: SIG_W];
  assign io_out_is_zero      = head_vis[FLAG_ZERO];
  assign io_out_is_subnormal = head_vis[FLAG_SUB];
  assign io_out_is_inf       = head_vis[FLAG_INF];
  assign io_out_is_nan       = head_vis[FLAG_NAN];

endmodule

// File: tb/tb_float_class_fifo.sv
// Directed self-checking bench for float_class_fifo (EXP_W=8, SIG_W=23, DEPTH=4).
module tb_float_class_fifo;

  logic        clock;
  logic        reset;
  logic        io_flush;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [31:0] io_in_bits;
  logic        io_out_valid;
  logic        io_out_ready;
  logic        io_out_sign;
  logic [7:0]  io_out_exponent;
  logic [22:0] io_out_significand;
  logic        io_out_is_zero;
  logic        io_out_is_subnormal;
  logic        io_out_is_inf;
  logic        io_out_is_nan;
  logic [2:0]  io_count;

  int checks;
  int failures;

  float_class_fifo #(
    .EXP_W(8),
    .SIG_W(23),
    .DEPTH(4)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .io_flush           (io_flush),
    .io_in_valid        (io_in_valid),
    .io_in_ready        (io_in_ready),
    .io_in_bits         (io_in_bits),
    .io_out_valid       (io_out_valid),
    .io_out_ready       (io_out_ready),
    .io_out_sign        (io_out_sign),
    .io_out_exponent    (io_out_exponent),
    .io_out_significand (io_out_significand),
    .io_out_is_zero     (io_out_is_zero),
    .io_out_is_subnormal(io_out_is_subnormal),
    .io_out_is_inf      (io_out_is_inf),
    .io_out_is_nan      (io_out_is_nan),
    .io_count           (io_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Compare the head word and the flag nibble {nan, inf, sub, zero}.
  task automatic check_head(input string tag, input logic [31:0] w, input logic [3:0] f);
    check({tag, "_word"}, {io_out_sign, io_out_exponent, io_out_significand}, w);
    check({tag, "_flags"}, {io_out_is_nan, io_out_is_inf, io_out_is_subnormal, io_out_is_zero}, f);
  endtask

  task automatic push_word(input logic [31:0] w);
    io_in_valid = 1'b1;
    io_in_bits  = w;
    tick();
    io_in_valid = 1'b0;
  endtask

  logic [31:0] cls_words [4];
  logic [3:0]  cls_flags [4];
  logic [31:0] seq [12];

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    io_flush     = 1'b0;
    io_in_valid  = 1'b0;
    io_in_bits   = '0;
    io_out_ready = 1'b0;

    // Reset state.
    #12;
    check("rst_out_valid", io_out_valid, 0);
    check("rst_in_ready", io_in_ready, 1);
    check("rst_count", io_count, 0);
    reset = 1'b0;

    // Single word 1.0f; no bypass to the head in the push cycle.
    io_in_valid = 1'b1;
    io_in_bits  = 32'h3F80_0000;
    check("one_nobypass", io_out_valid, 0);
    tick();
    io_in_valid = 1'b0;
    check("one_count1", io_count, 1);
    check("one_valid", io_out_valid, 1);
    check_head("one_head", 32'h3F80_0000, 4'b0000);
    io_out_ready = 1'b1;
    tick();
    io_out_ready = 1'b0;
    check("one_count0", io_count, 0);
    check("one_empty", io_out_valid, 0);

    // Classification of special values, back-to-back.
    cls_words[0] = 32'h7F80_0000; cls_flags[0] = 4'b0100;
    cls_words[1] = 32'hFFC0_0000; cls_flags[1] = 4'b1000;
    cls_words[2] = 32'h0000_0001; cls_flags[2] = 4'b0010;
    cls_words[3] = 32'h8000_0000; cls_flags[3] = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      io_in_valid = 1'b1;
      io_in_bits  = cls_words[i];
      tick();
    end
    io_in_valid = 1'b0;
    check("cls_count4", io_count, 4);
    io_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_head($sformatf("cls%0d", i), cls_words[i], cls_flags[i]);
      tick();
    end
    io_out_ready = 1'b0;
    check("cls_drained", io_count, 0);

    // Full FIFO holds off the 5th word, even during a pop cycle.
    for (int i = 0; i < 4; i++) push_word(32'h4000_0000 + i);
    io_in_valid = 1'b1;
    io_in_bits  = 32'h4000_0004;
    check("full_count", io_count, 4);
    check("full_not_ready", io_in_ready, 0);
    tick();
    check("full_held_count", io_count, 4);
    io_out_ready = 1'b1;
    check("full_pop_not_ready", io_in_ready, 0);
    tick();
    io_out_ready = 1'b0;
    check("full_after_pop_count", io_count, 3);
    check("full_after_pop_ready", io_in_ready, 1);
    tick();
    io_in_valid = 1'b0;
    check("full_5th_accepted", io_count, 4);
    io_out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check_head($sformatf("full_drain%0d", i), 32'h4000_0000 + i, 4'b0000);
      tick();
    end
    io_out_ready = 1'b0;
    check("full_drained", io_count, 0);

    // Streaming push+pop across pointer wrap.
    for (int i = 0; i < 12; i++) seq[i] = 32'h3F80_0000 + 32'(i) * 32'h100;
    push_word(seq[0]);
    io_in_valid  = 1'b1;
    io_out_ready = 1'b1;
    for (int i = 1; i < 12; i++) begin
      io_in_bits = seq[i];
      check($sformatf("stream_count%0d", i), io_count, 1);
      check_head($sformatf("stream%0d", i - 1), seq[i-1], 4'b0000);
      tick();
    end
    io_in_valid = 1'b0;
    check_head("stream11", seq[11], 4'b0000);
    tick();
    io_out_ready = 1'b0;
    check("stream_empty", io_count, 0);

    // Flush discards stored entries and the same-cycle push.
    for (int i = 0; i < 3; i++) push_word(32'h4100_0000 + i);
    check("flush_pre_count", io_count, 3);
    io_flush    = 1'b1;
    io_in_valid = 1'b1;
    io_in_bits  = 32'h1234_5678;
    check("flush_cycle_ready", io_in_ready, 1);
    check("flush_cycle_valid", io_out_valid, 1);
    tick();
    io_flush    = 1'b0;
    io_in_valid = 1'b0;
    check("flush_count", io_count, 0);
    check("flush_valid", io_out_valid, 0);
    tick();
    check("flush_word_dropped", io_count, 0);
    push_word(32'h4228_0000);
    check("post_flush_count", io_count, 1);
    check_head("post_flush", 32'h4228_0000, 4'b0000);

    // Asynchronous reset mid-stream.
    push_word(32'hC000_0000);
    check("pre_rst_count", io_count, 2);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid", io_out_valid, 0);
    check("async_rst_count", io_count, 0);
    check("async_rst_ready", io_in_ready, 1);
`ifdef FLOAT_CLASS_FIFO_DONTCARE_ZERO_EN
    check_head("async_rst_zero", 32'h0, 4'b0000);
`endif
    #3;
    reset = 1'b0;
    tick();
    check("post_rst_count", io_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/float_class_fifo.md
Name: float_class_fifo

Overview:
- Parametrised successor to the fixed-width float-constant bundle block.
- Accepts packed IEEE-style float words (sign|exponent|significand) of configurable width over a valid/ready handshake.
- Splits each word into fields, classifies it (zero/subnormal/inf/nan), and buffers the result in a DEPTH-entry FIFO.
- Sits between a float producer and any consumer that wants pre-decoded fields.

Parameters:
- EXP_W, 8, exponent field width (>=2)
- SIG_W, 23, significand field width (>=1)
- DEPTH, 4, FIFO entries; power of two, >=2

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- io_flush  input  1  synchronous clear of all stored entries
- io_in_valid  input  1  producer has a word
- io_in_ready  output  1  FIFO can accept a word
- io_in_bits  input  1+EXP_W+SIG_W  packed float; MSB is sign
- io_out_valid  output  1  head entry available
- io_out_ready  input  1  consumer takes head entry
- io_out_sign  output  1  head sign
- io_out_exponent  output  EXP_W  head exponent
- io_out_significand  output  SIG_W  head significand
- io_out_is_zero  output  1  exponent==0 and significand==0
- io_out_is_subnormal  output  1  exponent==0 and significand!=0
- io_out_is_inf  output  1  exponent all-ones and significand==0
- io_out_is_nan  output  1  exponent all-ones and significand!=0
- io_count  output  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (async assert, sync release): wr_ptr=0, rd_ptr=0, count=0. Resulting outputs: io_out_valid=0, io_in_ready=1, io_count=0. Storage contents are not reset.
- Push: occurs when io_in_valid & io_in_ready & !io_flush.
  - Fields are split and classified combinationally at input.
  - Entry stored is {sign, exp, sig, 4 class flags}.
  - Entry is visible at the head no earlier than the next cycle; no input-to-output bypass.
- Pop: occurs when io_out_valid & io_out_ready & !io_flush.
- io_in_ready = (count != DEPTH). It does not depend on io_out_ready, so a full FIFO refuses a push even in a pop cycle.
- io_out_valid = (count != 0). Output fields and flags come from the head entry register array, with no extra latency.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Classification flags are mutually exclusive. All four flags = 0 means a normal number.
- io_flush: on the next edge, pointers=0 and count=0. A push or pop in the same cycle is discarded. io_in_ready and io_out_valid still reflect the pre-flush state in the flush cycle.
- Reset asserted mid-stream: all entries are discarded immediately (io_out_valid drops asynchronously).
- Producer must hold io_in_bits stable while io_in_valid=1 and not accepted. The block does not check this.

Optional Feature:
- Macro: FLOAT_CLASS_FIFO_DONTCARE_ZERO_EN.
- Defined: while io_out_valid=0, io_out_sign, exponent, significand and all flags are forced to 0, matching the team's DontCare-to-zero convention.
- Undefined: those outputs show the raw storage at rd_ptr even when io_out_valid=0. Their value is unspecified and the bench must not check it.

Decomposition:
- Package float_class_pkg:
  - localparam helpers for word width (1+EXP_W+SIG_W) and entry width (word+4).
  - Flag bit-index constants: ZERO=0, SUB=1, INF=2, NAN=3.
  - A function for all-ones exponent detection.
- Sub-module float_classify: purely combinational. Input is the packed word; outputs are the split fields and four flags. Instantiated once on the input side.
- FIFO control (pointers, count, flush) lives in the top module.

Test Plan:
- EXP_W=8, SIG_W=23; push 0x3F800000, pop next cycle -> sign=0, exponent=0x7F, significand=0, all flags 0; io_count 1 then 0.
- Push 0x7F800000, 0xFFC00000, 0x00000001, 0x80000000 back-to-back, pop all -> in order: is_inf; is_nan with sign=1; is_subnormal with significand=1; is_zero with sign=1.
- DEPTH=4, io_out_ready=0, push 5 words -> io_in_ready=0 after 4th accept, io_count=4, 5th word held; then pop once -> io_in_ready=1 next cycle, 5th word accepted.
- Continuous push+pop at full throughput for 3*DEPTH words -> FIFO order preserved across pointer wrap, io_count constant at 1.
- Fill 3 entries, assert io_flush with io_in_valid=1 -> next cycle io_count=0, io_out_valid=0, flushed-cycle word not stored.
- Assert reset asynchronously mid-stream -> io_out_valid=0 and io_count=0 before the next clock edge. With FLOAT_CLASS_FIFO_DONTCARE_ZERO_EN defined, all output fields read 0.
